// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// One result bit per cycle: shift-add multiply, restoring divide.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_araw;
  logic             r_div;
  logic             r_negq;
  logic             r_negr;
  logic             r_dz;

  logic             w_sgn;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_n;
  logic [WIDTH-1:0] w_q_n;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fhi;
  logic [WIDTH-1:0] w_flo;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Operand magnitudes for the signed ops; MIN_INT maps to 2^(WIDTH-1).
  assign w_sgn   = ~op[0];
  assign w_abs_a = (w_sgn && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_abs_b = (w_sgn && op_b[WIDTH-1]) ? -op_b : op_b;

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    w_rsh  = {r_acc, r_q[WIDTH-1]};
    w_diff = w_rsh - {1'b0, r_m};
    if (r_div) begin
      if (!w_diff[WIDTH]) begin
        w_acc_n = w_diff[WIDTH-1:0];
        w_q_n   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_n = w_rsh[WIDTH-1:0];
        w_q_n   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_n = w_sum[WIDTH:1];
      w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    w_prod = {r_acc, r_q};
    if (r_negq && !r_div) w_prod = -w_prod;
    if (!r_div) begin
      w_fhi = w_prod[2*WIDTH-1:WIDTH];
      w_flo = w_prod[WIDTH-1:0];
    end else if (r_dz) begin
      w_fhi = r_araw;
      w_flo = '1;
    end else begin
      w_fhi = r_negr ? -r_acc : r_acc;
      w_flo = r_negq ? -r_q : r_q;
    end
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_araw  <= '0;
      r_div   <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            unique case (1'b1)
              !op[2]: begin
                r_div   <= op[1];
                r_acc   <= '0;
                r_q     <= w_abs_a;
                r_m     <= w_abs_b;
                r_araw  <= op_a;
                r_negq  <= w_sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                r_negr  <= w_sgn & op_a[WIDTH-1];
                r_dz    <= op[1] & (op_b == '0);
                r_cnt   <= CW'(WIDTH);
                r_state <= S_RUN;
              end
              (op == 3'b100): r_hi <= op_a;
              (op == 3'b101): r_lo <= op_a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_n;
            r_q   <= w_q_n;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!flush) begin
            r_hi   <= w_fhi;
            r_lo   <= w_flo;
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit (WIDTH=32).
// Directed vectors; a monitor pops expected HI/LO on every done pulse.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] sb[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done",
                 hi, lo);
      end else begin
        logic [2*W-1:0] e;
        e = sb.pop_front();
        chk("res_hi", hi, e[2*W-1:W]);
        chk("res_lo", lo, e[W-1:0]);
      end
    end
  end

  task automatic launch(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    start = 1'b1;
    op = o;
    op_a = a;
    op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (busy && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, W'(k), W'(W + 1));
    chk({nm, "_done"}, W'(done), W'(1));
  endtask

  task automatic mdop(input string nm, input logic [2:0] o,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eh, input logic [W-1:0] el);
    sb.push_back({eh, el});
    m_hi = eh;
    m_lo = el;
    launch(o, a, b);
    wait_done(nm);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    rst_n = 1'b1;
    @(negedge clk);

    mdop("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'hFFFFFFFE, 32'h00000001);
    mdop("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7,
         32'hFFFFFFFF, 32'hFFFFFFEB);

    launch(3'b100, 32'h1234, '0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, m_lo);
    chk("mthi_busy", W'(busy), '0);
    chk("mthi_done", W'(done), '0);
    m_hi = 32'h1234;

    launch(3'b101, 32'h5678, '0);
    chk("mtlo_lo", lo, 32'h5678);
    m_lo = 32'h5678;

    launch(3'b110, 32'hAAAA, 32'd3);
    chk("nop_busy", W'(busy), '0);
    chk("nop_hi", hi, m_hi);
    chk("nop_lo", lo, m_lo);

    mdop("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2,
         32'hFFFFFFFF, 32'hFFFFFFFD);
    mdop("div_pos_negb", 3'b010, 32'd7, 32'hFFFFFFFE,
         32'h00000001, 32'hFFFFFFFD);
    mdop("div_minint", 3'b010, 32'h80000000, 32'hFFFFFFFF,
         32'h00000000, 32'h80000000);
    mdop("mult_minsq", 3'b000, 32'h80000000, 32'h80000000,
         32'h40000000, 32'h00000000);
    mdop("divu_zero", 3'b011, 32'd100, 32'd0,
         32'h00000064, 32'hFFFFFFFF);
    mdop("div_zero", 3'b010, 32'hFFFFFFFB, 32'd0,
         32'hFFFFFFFB, 32'hFFFFFFFF);

    launch(3'b001, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op = 3'b101;
    op_a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    chk("drop_lo", lo, m_lo);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", W'(busy), '0);
    repeat (40) @(negedge clk);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);

    mdop("divu_9_4", 3'b011, 32'd9, 32'd4, 32'd1, 32'd2);
    mdop("b2b_multu", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15);

    launch(3'b001, 32'd11, 32'd13);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    chk("arst_busy", W'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mdop("mult_min_one", 3'b000, 32'h80000000, 32'd1,
         32'hFFFFFFFF, 32'h80000000);

    repeat (3) @(negedge clk);
    chk("sb_empty", W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
